// File: rtl/dram_resp.sv
// -----------------------------------------------------------------------------
// dram_resp
//
// Single-port SRAM front end with a posted write buffer and one-cycle read
// responses. Writes are always accepted into a small FIFO and drained to the
// SRAM in the background. Reads take the SRAM port ahead of the drain unless
// the buffer is full. A read that hits a pending write, or a write arriving in
// the same cycle, is answered from the buffered data instead of from the SRAM.
//
// Parameters
//   DATA_WIDTH  data word width
//   ADDR_WIDTH  word address width
//   WBUF_DEPTH  write-buffer entries (power of two, >= 2)
//
// Ports
//   clk, srstn               clock, asynchronous active-low reset
//   rd_en, rd_addr           read request (held by the initiator until rd_ready)
//   rd_ready                 read accepted this cycle
//   rd_data, rd_valid        read response, one cycle after acceptance
//   wr_en, wr_addr, wr_data  write request, always accepted
//   wbuf_empty               no write pending in the buffer
//   sram_cen, sram_wen       SRAM enable / write select
//   sram_addr, sram_wdata    SRAM address and write data
//   sram_rdata               SRAM read data, one cycle after a read access
// -----------------------------------------------------------------------------
module dram_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wbuf_empty,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_DRAIN
    } arb_t;

    logic [ADDR_WIDTH-1:0] buf_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data [WBUF_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    // Low during reset and for the first cycle after release, so that cycle
    // behaves as idle regardless of the request inputs.
    logic                  live;

    arb_t                  arb;
    logic                  push;
    logic                  drain;
    logic                  accept;

    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PW-1:0]         idx;

    logic                  vld_p1;
    logic                  fwd_hit_p1;
    logic [DATA_WIDTH-1:0] fwd_data_p1;

    // -------------------------------------------------------------------------
    // Stage p0: SRAM port arbitration, write enqueue, forwarding lookup
    // -------------------------------------------------------------------------
    always_comb begin
        arb = ARB_IDLE;
        if (!live) begin
            arb = ARB_IDLE;
        end else if (count == FULL_CNT) begin
            arb = ARB_DRAIN;
        end else if (rd_en) begin
            arb = ARB_READ;
        end else if (count != '0) begin
            arb = ARB_DRAIN;
        end
    end

    assign rd_ready   = (arb == ARB_READ);
    assign accept     = rd_ready;
    assign drain      = (arb == ARB_DRAIN);
    assign push       = wr_en & live;
    assign wbuf_empty = (count == '0);

    always_comb begin
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (arb)
            ARB_DRAIN: begin
                sram_cen   = 1'b1;
                sram_wen   = 1'b1;
                sram_addr  = buf_addr[head];
                sram_wdata = buf_data[head];
            end
            ARB_READ: begin
                sram_cen  = 1'b1;
                sram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    // Walk the live entries oldest to newest so the last match (newest write)
    // wins; a same-cycle write overrides everything buffered.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (buf_addr[idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[idx];
            end
        end
        if (push && (wr_addr == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= wr_addr;
            buf_data[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            live  <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            live <= 1'b1;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(drain);
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: read response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            vld_p1      <= 1'b0;
            fwd_hit_p1  <= 1'b0;
            fwd_data_p1 <= '0;
        end else begin
            vld_p1      <= accept;
            fwd_hit_p1  <= accept & fwd_hit;
            fwd_data_p1 <= (accept && fwd_hit) ? fwd_data : '0;
        end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = !vld_p1   ? '0          :
                      fwd_hit_p1 ? fwd_data_p1 : sram_rdata;

endmodule

// File: doc/dram_resp.md
DRAM_RESP -- requirements
Module: dram_resp

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of read and write data words.
REQ-002 Parameter ADDR_WIDTH, default 18: word address width.
REQ-003 Parameter WBUF_DEPTH, default 4: write-buffer entries, a power of two and at least 2.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port srstn, input, 1: reset, asynchronous and active-low.
REQ-006 Port rd_en, input, 1: read request from the initiator.
REQ-007 Port rd_addr, input, ADDR_WIDTH: read word address.
REQ-008 Port rd_ready, output, 1: the read request is accepted this cycle.
REQ-009 Port rd_data, output, DATA_WIDTH: read data, valid when rd_valid is high.
REQ-010 Port rd_valid, output, 1: rd_data carries the response to the read accepted in the previous cycle.
REQ-011 Port wr_en, input, 1: write request; always accepted.
REQ-012 Port wr_addr, input, ADDR_WIDTH: write word address.
REQ-013 Port wr_data, input, DATA_WIDTH: write data.
REQ-014 Port wbuf_empty, output, 1: no write is pending; the initiator uses it to qualify done.
REQ-015 Port sram_cen, output, 1: SRAM access enable, active-high.
REQ-016 Port sram_wen, output, 1: SRAM write (1) or read (0).
REQ-017 Port sram_addr, output, ADDR_WIDTH: SRAM address.
REQ-018 Port sram_wdata, output, DATA_WIDTH: SRAM write data.
REQ-019 Port sram_rdata, input, DATA_WIDTH: SRAM read data, valid one cycle after a read access.

Function
REQ-020 The block SHALL hold a FIFO write buffer of WBUF_DEPTH entries (address plus data) with a count register from 0 to WBUF_DEPTH.
REQ-021 A cycle with wr_en high SHALL enqueue {wr_addr, wr_data} at that clock edge.
REQ-022 The SRAM port SHALL be arbitrated every cycle in this priority order, with rd_ready as stated:
- count == WBUF_DEPTH: drain the head entry; rd_ready = 0.
- otherwise, rd_en high: read rd_addr; rd_ready = 1.
- otherwise, count > 0: drain the head entry.
- otherwise: idle, sram_cen = 0.
REQ-023 A drain SHALL drive sram_cen = 1, sram_wen = 1 and the head address/data, then pop the head at the edge.
REQ-024 Enqueue and drain in the same cycle SHALL leave count unchanged; a write is never dropped, including when the buffer is full.
REQ-025 An accepted read (rd_en and rd_ready high) SHALL produce rd_valid = 1 in exactly the next cycle; otherwise rd_valid = 0 in the next cycle.
REQ-026 A refused read produces no response; the initiator SHALL hold rd_en and rd_addr until accepted.
REQ-027 Read-after-write forwarding SHALL be evaluated in the accept cycle, in this priority order:
- a same-cycle wr_en with wr_addr == rd_addr;
- else the newest matching buffer entry;
- else SRAM.
REQ-028 A forwarded value SHALL be registered and presented on rd_data in the response cycle; otherwise rd_data = sram_rdata.
REQ-029 A buffer entry popped in the accept cycle SHALL still participate in matching.
REQ-030 When rd_valid = 0, rd_data SHALL be 0.
REQ-031 wbuf_empty SHALL equal (count == 0), combinationally from the registered count.
REQ-032 Addresses SHALL be compared over the full ADDR_WIDTH; FIFO pointers SHALL wrap modulo WBUF_DEPTH.
REQ-033 When sram_cen = 0, sram_wen, sram_addr and sram_wdata SHALL be 0.

Reset
REQ-034 While srstn is low, the following SHALL be forced immediately, independent of clk:
- count = 0 and both pointers = 0;
- rd_valid = 0 and rd_data = 0;
- forward registers cleared;
- wbuf_empty = 1 and sram_cen = 0.
REQ-035 Buffered writes pending at reset SHALL be discarded, and a read accepted in the cycle reset asserts SHALL produce no response.
REQ-036 The first edge after srstn rises SHALL behave as an idle, empty-buffer cycle.

Verification
REQ-037 Read 18'd65536 with no writes pending, SRAM holding 32'h0000_1234 -> rd_valid = 1 next cycle with rd_data = 32'h0000_1234.
REQ-038 Write 18'd131072 = 32'hA in cycle N and read 18'd131072 in cycle N+1 with the entry undrained -> response carries 32'hA and SRAM is untouched until the drain.
REQ-039 Read and write to 18'd5 in the same cycle, write data 32'h7 -> response carries 32'h7.
REQ-040 Write every cycle while reading every cycle until count = 4 -> the next cycle has rd_ready = 0, a drain occurs, and count stays 4.
REQ-041 Stop all requests after the REQ-040 scenario -> 4 drain cycles in FIFO order, then wbuf_empty = 1 and sram_cen = 0.
REQ-042 Assert srstn low with 3 writes buffered and a read outstanding -> count = 0, rd_valid = 0 and wbuf_empty = 1 immediately, and no SRAM write follows.
